// File: rtl/button_pkg.sv
// Shared key indices and per-key FSM encoding for the button front end.
// Pure declarations: no logic, no latency, no flow control.
package button_pkg;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int NUM_KEYS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_WAIT = 2'd1,
    ST_REPEAT    = 2'd2
  } btn_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One key: 2-flop sync, stability-count debounce, press/repeat pulse FSM.
// Pulse lands DEBOUNCE_CYCLES+2 edges after the raw press; no backpressure, pulses are fire-and-forget.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_raw,
  output logic o_pulse,
  output logic o_held
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RP_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic            w_p;
  logic            r_sync1, r_sync2;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_held;
  logic            w_accept, w_rise, w_fall;

  btn_state_t      r_state, w_state_nxt;
  logic [RP_W-1:0] r_rep_cnt, w_rep_nxt;
  logic            r_pulse, w_pulse_nxt;

  assign w_p = (ACTIVE_LOW != 0) ? ~i_key_raw : i_key_raw;

  // Sync flops reset to "released" so leaving reset never looks like a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db_cnt <= '0;
      r_held   <= 1'b0;
    end else begin
      r_sync1 <= w_p;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_held) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt >= DB_LAST) begin
        r_held   <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_accept = (r_sync2 != r_held) && (r_db_cnt >= DB_LAST);
  assign w_rise   = w_accept &  r_sync2;
  assign w_fall   = w_accept & ~r_sync2;

  always_comb begin
    w_state_nxt = r_state;
    w_rep_nxt   = r_rep_cnt;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_HOLD_WAIT;
          w_pulse_nxt = 1'b1;
          w_rep_nxt   = '0;
        end
      end
      ST_HOLD_WAIT: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_rep_nxt   = '0;
        end else if (REPEAT_EN != 0) begin
          if (r_rep_cnt >= RD_LAST) begin
            w_state_nxt = ST_REPEAT;
            w_pulse_nxt = 1'b1;
            w_rep_nxt   = '0;
          end else begin
            w_rep_nxt = r_rep_cnt + RP_W'(1);
          end
        end
      end
      ST_REPEAT: begin
        // Release wins over a repeat that would fire on the same edge.
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_rep_nxt   = '0;
        end else if (r_rep_cnt >= RP_LAST) begin
          w_pulse_nxt = 1'b1;
          w_rep_nxt   = '0;
        end else begin
          w_rep_nxt = r_rep_cnt + RP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rep_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_rep_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  assign o_pulse = r_pulse;
  assign o_held  = r_held;

endmodule

// File: rtl/button_conditioner.sv
// Four independent key channels mapped onto named press/repeat pulses and debounced levels.
// Pulses DEBOUNCE_CYCLES+2 edges after a raw press, 1 cycle wide; no backpressure, no priority between keys.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic                btn_up,
  output logic                btn_down,
  output logic                btn_left,
  output logic                btn_right,
  output logic [NUM_KEYS-1:0] btn_held,
  output logic                any_press
);

  logic [NUM_KEYS-1:0] w_pulse;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_key_raw(key_raw[i]),
      .o_pulse  (w_pulse[i]),
      .o_held   (btn_held[i])
    );
  end

  assign btn_up    = w_pulse[KEY_UP];
  assign btn_down  = w_pulse[KEY_DOWN];
  assign btn_left  = w_pulse[KEY_LEFT];
  assign btn_right = w_pulse[KEY_RIGHT];
  assign any_press = |w_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: reference model predicts per-cycle pulses/levels for a repeat and a no-repeat instance.
// Stimulus pushes expectations; a separate monitor pops and compares one cycle later.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_raw = 4'hF;

  logic       up, down, left, right, anyp;
  logic [3:0] held;
  logic       up_n, down_n, left_n, right_n, anyp_n;
  logic [3:0] held_n;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .btn_up(up), .btn_down(down), .btn_left(left), .btn_right(right),
    .btn_held(held), .any_press(anyp)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .ACTIVE_LOW(1)
  ) dut_nr (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .btn_up(up_n), .btn_down(down_n), .btn_left(left_n), .btn_right(right_n),
    .btn_held(held_n), .any_press(anyp_n)
  );

  typedef struct packed {
    logic [3:0] pulse;
    logic [3:0] held;
    logic       any;
    logic [3:0] pulse_nr;
    logic [3:0] held_nr;
    logic       any_nr;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: sync delay line, accepted level, recent synced samples, press time.
  bit m_p0[4];
  bit m_p1[4];
  bit m_d[4];
  bit m_sq[4][$];
  int m_press[4];
  int m_n = 0;

  task automatic model_step(input logic [3:0] kr, input logic r);
    exp_t e;
    e = '0;
    m_n++;
    for (int k = 0; k < 4; k++) begin
      if (r) begin
        m_p0[k] = 1'b0;
        m_p1[k] = 1'b0;
        m_d[k]  = 1'b0;
        m_sq[k].delete();
        m_press[k] = -1;
      end else begin
        bit s;
        bit stable;
        s = m_p1[k];
        m_p1[k] = m_p0[k];
        m_p0[k] = ~kr[k];
        m_sq[k].push_back(s);
        if (m_sq[k].size() > DB) void'(m_sq[k].pop_front());
        stable = (m_sq[k].size() == DB);
        foreach (m_sq[k][j]) if (m_sq[k][j] == m_d[k]) stable = 1'b0;
        if (stable) begin
          m_d[k] = s;
          m_sq[k].delete();
          if (s) begin
            e.pulse[k]    = 1'b1;
            e.pulse_nr[k] = 1'b1;
            m_press[k]    = m_n;
          end
        end else if (m_d[k]) begin
          int age;
          age = m_n - m_press[k];
          if (age == RD || (age > RD && (age - RD) % RP == 0)) e.pulse[k] = 1'b1;
        end
      end
      e.held[k]    = m_d[k];
      e.held_nr[k] = m_d[k];
    end
    e.any    = |e.pulse;
    e.any_nr = |e.pulse_nr;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] kr, input logic r);
    @(posedge clk);
    #2;
    key_raw = kr;
    rst     = r;
    model_step(kr, r);
  endtask

  task automatic hold(input logic [3:0] kr, input int n);
    for (int i = 0; i < n; i++) cyc(kr, 1'b0);
  endtask

  task automatic chk(input string nm, input int c, input logic [3:0] act, input logic [3:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, c, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents its registered outputs; compare against the oldest prediction.
  initial begin
    exp_t e;
    int   c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pulse",    c, {right, left, down, up}, e.pulse);
        chk("held",     c, held, e.held);
        chk("any",      c, {3'b000, anyp}, {3'b000, e.any});
        chk("pulse_nr", c, {right_n, left_n, down_n, up_n}, e.pulse_nr);
        chk("held_nr",  c, held_n, e.held_nr);
        chk("any_nr",   c, {3'b000, anyp_n}, {3'b000, e.any_nr});
      end
    end
  end

  initial begin
    logic [3:0] kr;
    for (int k = 0; k < 4; k++) m_press[k] = -1;

    cyc(4'hF, 1'b1);
    cyc(4'hF, 1'b1);
    cyc(4'hF, 1'b0);
    hold(4'hF, 5);

    // Up pressed and held: first pulse plus repeats.
    hold(4'hE, 30);
    hold(4'hF, 12);

    // Short glitch on down.
    hold(4'hD, 3);
    hold(4'hF, 10);

    // Left bounces, then settles pressed.
    for (int i = 0; i < 3; i++) begin
      hold(4'hB, 2);
      hold(4'hF, 2);
    end
    hold(4'hB, 20);
    hold(4'hF, 12);

    // Up and right together.
    hold(4'h6, 20);
    hold(4'hF, 12);

    // Reset while up is in its hold-wait window.
    hold(4'hE, 10);
    cyc(4'hE, 1'b1);
    hold(4'hE, 30);
    hold(4'hF, 12);

    // Long hold on right then release.
    hold(4'h7, 50);
    hold(4'hF, 12);

    // Randomised key activity with occasional reset.
    kr = 4'hF;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) kr[k] = ~kr[k];
      cyc(kr, ($urandom_range(0, 249) == 0));
    end
    hold(4'hF, 2);

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
